// File: rtl/bsg_wormhole_rr_link_arbiter.sv
// Round-robin, packet-atomic arbiter merging num_in_p wormhole ready-and streams onto one link.
// The grant is chosen combinationally in IDLE and held on one input until the packet's last body flit.
module bsg_wormhole_rr_link_arbiter #(
  parameter int num_in_p     = 2,
  parameter int width_p      = 80,
  parameter int cord_width_p = 7,
  parameter int len_width_p  = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [num_in_p-1:0]         v_i,
  input  logic [num_in_p*width_p-1:0] data_i,
  output logic [num_in_p-1:0]         ready_and_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  input  logic                        ready_and_i,
  output logic [num_in_p-1:0]         grant_o,
  output logic                        locked_o
);

  localparam int lg_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [lg_lp-1:0]       last_q, last_d;
  logic [lg_lp-1:0]       gnt_q, gnt_d;
  logic [len_width_p-1:0] cnt_q, cnt_d;

  logic [width_p-1:0]     in_data [num_in_p];
  logic [lg_lp-1:0]       cand    [num_in_p];

  logic                   idle_hit;
  logic [lg_lp-1:0]       idle_sel;
  logic                   sel_act;
  logic [lg_lp-1:0]       sel_idx;
  logic                   active;
  logic                   xfer;
  logic [len_width_p-1:0] hdr_len;

  // cand[gi] is (last_q + gi + 1) mod num_in_p; one conditional subtract suffices
  // because last_q < num_in_p and the offset is at most num_in_p.
  genvar gi;
  generate
    for (gi = 0; gi < num_in_p; gi++) begin : g_cand
      logic [lg_lp:0] sum;
      assign in_data[gi] = data_i[gi*width_p +: width_p];
      assign sum         = {1'b0, last_q} + (lg_lp+1)'(gi + 1);
      assign cand[gi]    = (sum >= (lg_lp+1)'(num_in_p))
                         ? lg_lp'(sum - (lg_lp+1)'(num_in_p))
                         : sum[lg_lp-1:0];
    end
  endgenerate

  // Smallest rotation offset with a valid input wins.
  always_comb begin
    idle_hit = 1'b0;
    idle_sel = '0;
    for (int i = num_in_p - 1; i >= 0; i--) begin
      if (v_i[cand[i]]) begin
        idle_hit = 1'b1;
        idle_sel = cand[i];
      end
    end
  end

  always_comb begin
    sel_act = (state_q == LOCKED) || idle_hit;
    sel_idx = (state_q == LOCKED) ? gnt_q : idle_sel;
    active  = sel_act && !reset_i;

    v_o      = active && v_i[sel_idx];
    data_o   = sel_act ? in_data[sel_idx] : in_data[0];
    locked_o = (state_q == LOCKED) && !reset_i;

    grant_o     = '0;
    ready_and_o = '0;
    for (int i = 0; i < num_in_p; i++) begin
      grant_o[i]     = active && (sel_idx == lg_lp'(i));
      ready_and_o[i] = grant_o[i] && ready_and_i;
    end

    xfer    = v_o && ready_and_i;
    hdr_len = data_o[cord_width_p +: len_width_p];
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_len == '0) begin
            last_d = idle_sel;
          end else begin
            state_d = LOCKED;
            gnt_d   = idle_sel;
            cnt_d   = hdr_len;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == len_width_p'(1)) begin
            state_d = IDLE;
            last_d  = gnt_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset priority points at the last input so input 0 is served first.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= lg_lp'(num_in_p - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_rr_link_arbiter.sv
// Self-checking bench: directed vector table, corner-case sequences and
// randomized wormhole sources against a packet-level reference model.
module tb_bsg_wormhole_rr_link_arbiter;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int CW = 7;
  localparam int LW = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ready_and_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           ready_and_i;
  logic [N-1:0]   grant_o;
  logic           locked_o;

  logic [W-1:0]   din [N];

  bsg_wormhole_rr_link_arbiter #(
    .num_in_p(N), .width_p(W), .cord_width_p(CW), .len_width_p(LW)
  ) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .data_i(data_i),
    .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o),
    .ready_and_i(ready_and_i), .grant_o(grant_o), .locked_o(locked_o)
  );

  always_comb begin
    data_i = '0;
    for (int k = 0; k < N; k++) data_i[k*W +: W] = din[k];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] hdr(input int tag, input int len, input int cord);
    return {5'(tag), 4'(len), 7'(cord)};
  endfunction

  // Reference model: who owns the link, how many body flits remain, who finished last.
  bit           m_busy;
  int           m_owner, m_left, m_last;
  int           esel;
  logic         ev, el;
  logic [N-1:0] eg, er;
  logic [W-1:0] ed;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_left = 0; m_last = N - 1;
  endtask

  task automatic model_eval();
    esel = -1;
    if (m_busy) esel = m_owner;
    else
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (esel < 0 && v_i[idx]) esel = idx;
      end
    ev = 0; eg = '0; er = '0; el = 0; ed = din[0];
    if (!rst && esel >= 0) begin
      eg = N'(1) << esel;
      ev = v_i[esel];
      er = ready_and_i ? eg : '0;
      el = m_busy;
      ed = din[esel];
    end
  endtask

  task automatic model_update();
    int len;
    if (!m_busy) begin
      len = int'(ed[CW +: LW]);
      if (len == 0) m_last = esel;
      else begin m_busy = 1; m_owner = esel; m_left = len; end
    end else begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_last = m_owner; end
    end
  endtask

  logic         obs_xfer;
  logic [N-1:0] obs_ready, obs_grant;
  logic [W-1:0] obs_data;
  logic [23:0]  obs_vec;

  // Called at a negedge with inputs driven; samples, checks, crosses one posedge.
  task automatic step(input string tag);
    bit hs;
    #1;
    model_eval();
    obs_xfer  = v_o & ready_and_i;
    obs_ready = ready_and_o;
    obs_grant = grant_o;
    obs_data  = data_o;
    obs_vec   = {v_o, grant_o, ready_and_o, locked_o, data_o};
    check(tag, obs_vec, {ev, eg, er, el, ed});
    if (obs_xfer)
      $display("xfer %-6s t=%0t grant=%b data=%h locked=%b", tag, $time, grant_o, data_o, locked_o);
    hs = ev && ready_and_i;
    @(posedge clk);
    if (hs) model_update();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; v_i = '1; ready_and_i = 1'b1;
    for (int k = 0; k < N; k++) din[k] = hdr(k, 0, 0);
    #1;
    check("reset_out", {v_o, ready_and_o, grant_o, locked_o}, '0);
    @(posedge clk);
    @(negedge clk);
    v_i = '0;
    rst = 1'b0;
    model_reset();
    check("reset_regs", {locked_o, dut.cnt_q}, '0);
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [W-1:0] d0, d1;
    logic         rdy;
    logic [N-1:0] eg;
    logic         el;
    logic [W-1:0] ed;
  } vec_t;

  vec_t tbl [9];

  logic [W-1:0] bp    [4];
  int           bp_cnt[4];
  logic [N-1:0] src_v;
  logic [W-1:0] src_d [N];
  int           pend  [N];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, hs, exp_cnt, len;

    // fairness (rows 0-3), atomicity with input 1 waiting (rows 4-8)
    for (int r = 0; r < 4; r++) begin
      tbl[r].v = 3'b011; tbl[r].d0 = hdr(1, 0, 0); tbl[r].d1 = hdr(2, 0, 1); tbl[r].rdy = 1;
      tbl[r].eg = (r % 2 == 0) ? 3'b001 : 3'b010; tbl[r].el = 0;
      tbl[r].ed = (r % 2 == 0) ? hdr(1, 0, 0) : hdr(2, 0, 1);
    end
    tbl[4] = '{3'b011, hdr(3, 3, 5), hdr(4, 0, 1), 1'b1, 3'b001, 1'b0, hdr(3, 3, 5)};
    tbl[5] = '{3'b011, 16'hB001,     hdr(4, 0, 1), 1'b1, 3'b001, 1'b1, 16'hB001};
    tbl[6] = '{3'b011, 16'hB002,     hdr(4, 0, 1), 1'b1, 3'b001, 1'b1, 16'hB002};
    tbl[7] = '{3'b011, 16'hB003,     hdr(4, 0, 1), 1'b1, 3'b001, 1'b1, 16'hB003};
    tbl[8] = '{3'b010, 16'h0000,     hdr(4, 0, 1), 1'b1, 3'b010, 1'b0, hdr(4, 0, 1)};

    model_reset();
    reset_dut();
    for (int r = 0; r < 9; r++) begin
      v_i = tbl[r].v; din[0] = tbl[r].d0; din[1] = tbl[r].d1; din[2] = '0;
      ready_and_i = tbl[r].rdy;
      step("vec");
      check($sformatf("vec%0d", r), obs_vec,
            {|tbl[r].eg, tbl[r].eg, tbl[r].rdy ? tbl[r].eg : 3'b000, tbl[r].el, tbl[r].ed});
    end

    // wrap-around
    reset_dut();
    v_i = 3'b110; din[1] = hdr(1, 0, 0); din[2] = hdr(2, 0, 0); ready_and_i = 1;
    step("wrap");
    check("wrap_a", obs_grant, 3'b010);
    v_i = 3'b101; din[0] = hdr(3, 0, 0);
    step("wrap");
    check("wrap_b", obs_grant, 3'b100);

    // backpressure on a len=3 packet
    bp[0] = hdr(6, 3, 2); bp[1] = 16'hC101; bp[2] = 16'hC102; bp[3] = 16'hC103;
    bp_cnt[0] = 3; bp_cnt[1] = 2; bp_cnt[2] = 1; bp_cnt[3] = 0;
    idx = 0; hs = 0; exp_cnt = 0;
    for (int c = 0; c < 16 && idx < 4; c++) begin
      v_i = 3'b001; din[0] = bp[idx]; ready_and_i = (c % 2 == 0);
      step("bp");
      if (obs_xfer) begin
        check("bp_data", obs_data, bp[idx]);
        exp_cnt = bp_cnt[idx];
        idx++; hs++;
        check("bp_cnt", dut.cnt_q, exp_cnt);
      end else begin
        check("bp_hold", dut.cnt_q, exp_cnt);
      end
    end
    v_i = '0;
    check("bp_hs", hs, 4);
    check("bp_unlock", locked_o, 0);

    // maximum length packet
    for (int i = 0; i < 16; i++) begin
      v_i = 3'b001; ready_and_i = 1;
      din[0] = (i == 0) ? hdr(7, 15, 3) : W'(16'hD000 + i);
      step("max");
      check("max_flit", {obs_xfer, obs_data}, {1'b1, din[0]});
    end
    v_i = 3'b010; din[1] = hdr(9, 0, 0);
    check("max_idle", {locked_o, dut.cnt_q}, '0);
    step("max");
    check("max_next", obs_grant, 3'b010);

    // reset in the middle of a packet
    v_i = 3'b001; din[0] = hdr(8, 3, 0); ready_and_i = 1;
    step("mid");
    din[0] = 16'hE001;
    step("mid");
    check("mid_cnt", dut.cnt_q, 2);
    v_i = 3'b011; din[0] = 16'hE002; din[1] = hdr(10, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async", {v_o, ready_and_o, grant_o, locked_o}, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    v_i = '0;
    rst = 1'b0;
    for (int k = 0; k < N; k++) din[k] = hdr(11 + k, 0, 0);
    v_i = 3'b111;
    step("mid");
    check("mid_prio", obs_grant, 3'b001);

    // randomized sources honoring the hold-until-accepted contract
    reset_dut();
    src_v = '0;
    for (int k = 0; k < N; k++) begin pend[k] = 0; src_d[k] = '0; end
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!src_v[k]) begin
          if (pend[k] > 0) begin
            if ($urandom_range(0, 3) != 0) begin
              src_v[k] = 1; src_d[k] = W'($urandom); pend[k]--;
            end
          end else if ($urandom_range(0, 1) == 1) begin
            len = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 3));
            src_v[k] = 1; src_d[k] = hdr(int'($urandom_range(0, 31)), len, int'($urandom_range(0, 127)));
            pend[k] = len;
          end
        end
      end
      v_i = src_v;
      for (int k = 0; k < N; k++) din[k] = src_d[k];
      ready_and_i = ($urandom_range(0, 3) != 0);
      step("rand");
      for (int k = 0; k < N; k++)
        if (src_v[k] && obs_ready[k]) src_v[k] = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
